// File: rtl/bpsk_pkg.sv
// Shared types and constants for the BPSK transmitter.
// CORDIC arctangent table is in phase units where 65536 = 2*pi.
package bpsk_pkg;

    localparam int CORDIC_STAGES = 16;

    localparam logic signed [15:0] CORDIC_ATAN [0:CORDIC_STAGES-1] = '{
        16'sd8192, 16'sd4836, 16'sd2555, 16'sd1297, 16'sd651, 16'sd326,
        16'sd163,  16'sd81,   16'sd41,   16'sd20,   16'sd10,  16'sd5,
        16'sd3,    16'sd1,    16'sd1,    16'sd0
    };

    // Complex output sample; packs as {q, i}, matching the receiver's input word.
    typedef struct packed {
        logic signed [15:0] q;
        logic signed [15:0] i;
    } sample_t;

    typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} mod_state_t;

    // Symmetric clamp to +/-32767 so the output never reaches -32768.
    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767)       return 16'sd32767;
        else if (v < -32'sd32767) return -16'sd32767;
        else                      return v[15:0];
    endfunction

endpackage

// File: rtl/cordic_rotator.sv
// Rotation-mode CORDIC pipeline, one stage per register, with valid/last
// sideband travelling alongside the data. Every register advances only on ce,
// so backpressure freezes the whole pipe. The final stage's result is
// saturated straight into the output register (no gain compensation).
module cordic_rotator
    import bpsk_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic               in_valid,
    input  logic               in_last,
    input  logic signed [31:0] in_x,
    input  logic signed [31:0] in_y,
    input  logic signed [15:0] in_z,
    output logic               out_valid,
    output logic               out_last,
    output logic [3:0]         out_strb,
    output sample_t            out_data
);

    localparam int STAGES = CORDIC_STAGES;

    // vld_pipe[0] qualifies the stage-0 registers, vld_pipe[STAGES] the output.
    logic [STAGES:0]    vld_pipe;
    logic [STAGES:0]    last_pipe;
    logic signed [31:0] x_r [STAGES];
    logic signed [31:0] y_r [STAGES];
    logic signed [15:0] z_r [STAGES];
    logic signed [31:0] x_n [STAGES];
    logic signed [31:0] y_n [STAGES];

    // Micro-rotation of every stage; direction chosen by the residual angle sign.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            if (z_r[i] >= 16'sd0) begin
                x_n[i] = x_r[i] - (y_r[i] >>> i);
                y_n[i] = y_r[i] + (x_r[i] >>> i);
            end else begin
                x_n[i] = x_r[i] + (y_r[i] >>> i);
                y_n[i] = y_r[i] - (x_r[i] >>> i);
            end
        end
    end

    // Pipeline registers, sideband shift registers and saturated output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            out_strb  <= '0;
            out_data  <= '0;
            for (int i = 0; i < STAGES; i++) begin
                x_r[i] <= '0;
                y_r[i] <= '0;
                z_r[i] <= '0;
            end
        end else if (ce) begin
            vld_pipe  <= {vld_pipe[STAGES-1:0], in_valid};
            last_pipe <= {last_pipe[STAGES-1:0], in_last};
            x_r[0]    <= in_x;
            y_r[0]    <= in_y;
            z_r[0]    <= in_z;
            for (int i = 1; i < STAGES; i++) begin
                x_r[i] <= x_n[i-1];
                y_r[i] <= y_n[i-1];
                z_r[i] <= (z_r[i-1] >= 16'sd0) ? z_r[i-1] - CORDIC_ATAN[i-1]
                                               : z_r[i-1] + CORDIC_ATAN[i-1];
            end
            out_strb   <= {4{vld_pipe[STAGES-1]}};
            out_data.i <= sat16(x_n[STAGES-1]);
            out_data.q <= sat16(y_n[STAGES-1]);
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign out_last  = last_pipe[STAGES];

endmodule

// File: rtl/bpsk_modulator.sv
// BPSK transmitter: serializes AXIS bytes LSB first, holds each bit for SPS
// samples at +/-AMP, and rotates each sample by a free-running NCO phase in a
// CORDIC. Output word is {Q, I}.
// Optional feature: define BPSK_DIFF_EN for differential encoding
// (d_k = b_k ^ d_{k-1}), which removes the receiver's 180-degree ambiguity.
module bpsk_modulator
    import bpsk_pkg::*;
#(
    parameter int          C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int          C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int          SPS                    = 8,
    parameter logic [15:0] PHASE_INC              = 16'd0,
    parameter int          AMP                    = 16384
)(
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic                                  s00_axis_tvalid,
    output logic                                  s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    input  logic                                  s00_axis_tlast,
    output logic                                  m00_axis_tvalid,
    input  logic                                  m00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                                  m00_axis_tlast
);

    localparam int                 SW       = $clog2(SPS);
    localparam logic [SW-1:0]      SMP_LAST = SW'(SPS - 1);
    localparam logic signed [31:0] AMP_P    = 32'(AMP);
    localparam logic [0:0]         ST_IDLE  = IDLE;
    localparam logic [0:0]         ST_SEND  = SEND;

    logic [0:0]         state;
    logic               run;       // holds tready low until the first edge after reset
    logic [7:0]         byte_r;
    logic               last_r;
    logic [2:0]         bit_cnt;
    logic [SW-1:0]      smp_cnt;
    logic [15:0]        phase;
    logic               ce, issue, smp_end, byte_end, s_hs;
    logic               cur_bit, sym_bit;
    logic signed [31:0] amp_s, x0;
    logic signed [15:0] ph_s, z0;
    sample_t            out_data;
    logic [3:0]         out_strb;
    logic               unused_in;

    assign ce       = !m00_axis_tvalid || m00_axis_tready;
    assign issue    = (state == ST_SEND) && ce;
    assign smp_end  = (smp_cnt == SMP_LAST);
    assign byte_end = smp_end && (bit_cnt == 3'd7);
    // End-of-byte tready is combinational so the next byte follows with no gap.
    assign s00_axis_tready = run && ((state == ST_IDLE) || (issue && byte_end));
    assign s_hs     = s00_axis_tvalid && s00_axis_tready;
    assign cur_bit  = byte_r[bit_cnt];

`ifdef BPSK_DIFF_EN
    logic diff_r;
    assign sym_bit = cur_bit ^ diff_r;

    // Differential state advances once per bit; persists across frames.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn)   diff_r <= 1'b0;
        else if (issue && smp_end) diff_r <= sym_bit;
    end
`else
    assign sym_bit = cur_bit;
`endif

    // Pre-rotation folds phases beyond +/-90 deg into CORDIC range by negating x.
    always_comb begin
        amp_s = sym_bit ? AMP_P : -AMP_P;
        ph_s  = $signed(phase);
        x0    = amp_s;
        z0    = ph_s;
        if (ph_s > 16'sd16384 || ph_s < -16'sd16384) begin
            x0 = -amp_s;
            z0 = $signed(phase + 16'h8000);
        end
        if (!issue) begin
            x0 = '0;
            z0 = '0;
        end
    end

    // FSM, serializer counters and NCO; all frozen while ce is low in SEND.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state   <= ST_IDLE;
            run     <= 1'b0;
            byte_r  <= '0;
            last_r  <= 1'b0;
            bit_cnt <= '0;
            smp_cnt <= '0;
            phase   <= '0;
        end else begin
            run <= 1'b1;
            if (state == ST_IDLE) begin
                if (s_hs) begin
                    byte_r  <= s00_axis_tdata[7:0];
                    last_r  <= s00_axis_tlast;
                    bit_cnt <= '0;
                    smp_cnt <= '0;
                    state   <= ST_SEND;
                end
            end else if (ce) begin
                phase <= phase + PHASE_INC;
                if (smp_end) begin
                    smp_cnt <= '0;
                    if (bit_cnt == 3'd7) begin
                        bit_cnt <= '0;
                        if (s_hs) begin
                            byte_r <= s00_axis_tdata[7:0];
                            last_r <= s00_axis_tlast;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end else begin
                    smp_cnt <= smp_cnt + SW'(1);
                end
            end
        end
    end

    cordic_rotator u_cordic (
        .clk       (s00_axis_aclk),
        .rst_n     (s00_axis_aresetn),
        .ce        (ce),
        .in_valid  (issue),
        .in_last   (issue && byte_end && last_r),
        .in_x      (x0),
        .in_y      (32'sd0),
        .in_z      (z0),
        .out_valid (m00_axis_tvalid),
        .out_last  (m00_axis_tlast),
        .out_strb  (out_strb),
        .out_data  (out_data)
    );

    assign m00_axis_tdata = C_M00_AXIS_TDATA_WIDTH'(out_data);
    assign m00_axis_tstrb = out_strb;
    assign unused_in      = ^{s00_axis_tstrb, s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:8]};

endmodule

// File: tb/tb_bpsk_modulator.sv
// Bench for bpsk_modulator: three instances (PHASE_INC 0, 16384, 6151) share
// the input stream; outputs are checked against a real-arithmetic model
// (K*AMP*sign*exp(j*theta)) plus table vectors and timing corner cases.
module tb_bpsk_modulator;

    localparam int SPS    = 4;
    localparam int AMP    = 16384;
    localparam int ND     = 3;
    localparam int TOL    = 64;
    localparam int TOL_AX = 16;
    localparam int AX     = 26981;

    typedef struct { int i; int q; bit last; } smp_t;
    typedef struct { int dut; logic [7:0] b; int idx; int ei; int eq; } vec_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b1;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tstrb = '0;
    logic        s_tready [ND];
    logic        m_tvalid [ND];
    logic        m_tlast  [ND];
    logic [31:0] m_tdata  [ND];
    logic [3:0]  m_tstrb  [ND];

    int          ntests = 0, nfail = 0;
    int          cyc = 0, acc_cyc = 0;
    bit          rnd = 1'b0, dprev = 1'b0;
    longint      nsmp [ND];
    smp_t        expq [ND][$];
    smp_t        rxq  [ND][$];
    int          rxcyc [$];
    logic [7:0]  tx_b [$];
    bit          hold_v [ND];
    logic [31:0] hold_d [ND];
    real         kgain;
    vec_t        vt [12];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        bpsk_modulator #(
            .C_S00_AXIS_TDATA_WIDTH (32),
            .C_M00_AXIS_TDATA_WIDTH (32),
            .SPS                    (SPS),
            .PHASE_INC              (g == 0 ? 16'd0 : (g == 1 ? 16'd16384 : 16'd6151)),
            .AMP                    (AMP)
        ) u_dut (
            .s00_axis_aclk    (clk),
            .s00_axis_aresetn (rst_n),
            .s00_axis_tvalid  (s_tvalid),
            .s00_axis_tready  (s_tready[g]),
            .s00_axis_tdata   (s_tdata),
            .s00_axis_tstrb   (s_tstrb),
            .s00_axis_tlast   (s_tlast),
            .m00_axis_tvalid  (m_tvalid[g]),
            .m00_axis_tready  (m_tready),
            .m00_axis_tdata   (m_tdata[g]),
            .m00_axis_tstrb   (m_tstrb[g]),
            .m00_axis_tlast   (m_tlast[g])
        );
    end

    function automatic int inc_of(input int g);
        return (g == 0) ? 0 : ((g == 1) ? 16384 : 6151);
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_tol(input string nm, input int act, input int exp, input int tol);
        ntests++;
        if (act > exp + tol || act < exp - tol) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", nm, act, exp, tol);
        end
    endtask

    // Reference model: one accepted byte -> 8*SPS ideal rotated samples per DUT.
    task automatic model_byte(input logic [7:0] b, input bit lst);
        bit   d;
        real  s, th;
        smp_t e;
        int   ph;
        for (int j = 0; j < 8; j++) begin
            d = b[j];
`ifdef BPSK_DIFF_EN
            d = d ^ dprev;
            dprev = d;
`endif
            s = d ? 1.0 : -1.0;
            for (int k = 0; k < SPS; k++) begin
                for (int g = 0; g < ND; g++) begin
                    ph     = int'((nsmp[g] * longint'(inc_of(g))) % 65536);
                    th     = 2.0 * 3.14159265358979 * real'(ph) / 65536.0;
                    e.i    = int'(kgain * AMP * s * $cos(th));
                    e.q    = int'(kgain * AMP * s * $sin(th));
                    e.last = lst && (j == 7) && (k == SPS - 1);
                    expq[g].push_back(e);
                    nsmp[g]++;
                end
            end
        end
    endtask

    // Output monitor: collects handshaken samples, checks tstrb and hold stability.
    always @(negedge clk) begin
        smp_t r;
        for (int g = 0; g < ND; g++) begin
            if (hold_v[g]) begin
                check("hold_valid", m_tvalid[g], 1);
                check("hold_data", m_tdata[g], hold_d[g]);
            end
            hold_v[g] = m_tvalid[g] && !m_tready;
            hold_d[g] = m_tdata[g];
            check("tstrb", m_tstrb[g], m_tvalid[g] ? 15 : 0);
            if (m_tvalid[g] && m_tready) begin
                r.i    = int'($signed(m_tdata[g][15:0]));
                r.q    = int'($signed(m_tdata[g][31:16]));
                r.last = m_tlast[g];
                rxq[g].push_back(r);
                if (g == 0) rxcyc.push_back(cyc);
            end
        end
    end

    // Downstream ready: constant 1, or ~30% low when rnd is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = rnd ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < ND; g++) begin
            check("rst_tvalid", m_tvalid[g], 0);
            check("rst_tdata", m_tdata[g], 0);
            check("rst_tlast", m_tlast[g], 0);
            check("rst_tstrb", m_tstrb[g], 0);
            check("rst_s_tready", s_tready[g], 0);
            expq[g].delete();
            rxq[g].delete();
            nsmp[g] = 0;
            hold_v[g] = 1'b0;
        end
        rxcyc.delete();
        dprev = 1'b0;
        s_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Presents tx_b back-to-back; tlast on the final byte when lst is set.
    task automatic send_stream(input bit lst);
        bit acc;
        int n;
        for (int i = 0; i < tx_b.size(); i++) begin
            s_tvalid = 1'b1;
            s_tdata  = {24'h0, tx_b[i]};
            s_tlast  = lst && (i == tx_b.size() - 1);
            s_tstrb  = 4'($urandom);
            acc = 1'b0;
            n = 0;
            while (!acc && n < 5000) begin
                @(negedge clk);
                acc = s_tready[0];
                @(posedge clk);
                #1;
                n++;
            end
            check("accept_timeout", acc, 1);
            if (acc) begin
                if (i == 0) acc_cyc = cyc;
                model_byte(tx_b[i], s_tlast);
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (rxq[0].size() < expq[0].size() && n < 4000) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", rxq[0].size() >= expq[0].size(), 1);
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic compare_model(input string tag);
        int n;
        for (int g = 0; g < ND; g++) begin
            check({tag, "_count"}, rxq[g].size(), expq[g].size());
            n = (rxq[g].size() < expq[g].size()) ? rxq[g].size() : expq[g].size();
            for (int k = 0; k < n; k++) begin
                ntests++;
                if (rxq[g][k].i > expq[g][k].i + TOL || rxq[g][k].i < expq[g][k].i - TOL ||
                    rxq[g][k].q > expq[g][k].q + TOL || rxq[g][k].q < expq[g][k].q - TOL ||
                    rxq[g][k].last != expq[g][k].last) begin
                    nfail++;
                    $display("FAIL %s_sample dut%0d #%0d: got I=%0d Q=%0d last=%0b, expected I=%0d Q=%0d last=%0b (tol %0d)",
                             tag, g, k, rxq[g][k].i, rxq[g][k].q, rxq[g][k].last,
                             expq[g][k].i, expq[g][k].q, expq[g][k].last, TOL);
                end
            end
        end
    endtask

    initial begin
        int sg1 [8];
        int ngap, nl;
        kgain = 1.0;
        for (int i = 0; i < 16; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2.0 * i));
`ifdef BPSK_DIFF_EN
        sg1 = '{1, 1, -1, -1, -1, 1, 1, -1};
`else
        sg1 = '{1, -1, 1, -1, -1, 1, -1, 1};
`endif
        // Byte 0xA5 at phase 0: per-bit sign of I; byte 0xFF at 90-degree steps.
        for (int b = 0; b < 8; b++) vt[b] = '{0, 8'hA5, 4 * b + 2, sg1[b] * AX, 0};
        vt[8]  = '{1, 8'hFF, 0,  AX,   0};
        vt[9]  = '{1, 8'hFF, 1,  0,   AX};
        vt[10] = '{1, 8'hFF, 2, -AX,   0};
        vt[11] = '{1, 8'hFF, 3,  0,  -AX};

        for (int g = 0; g < ND; g++) begin nsmp[g] = 0; hold_v[g] = 1'b0; end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);

        // Table vectors
        for (int t = 0; t < 12; t++) begin
            if (t == 0 || vt[t].b != vt[t-1].b) begin
                do_reset();
                tx_b = '{vt[t].b};
                send_stream(1'b1);
                drain();
                compare_model("tbl");
                check("tbl_count32", rxq[0].size(), 8 * SPS);
            end
            if (vt[t].idx < rxq[vt[t].dut].size()) begin
                check_tol("tbl_i", rxq[vt[t].dut][vt[t].idx].i, vt[t].ei, TOL_AX);
                check_tol("tbl_q", rxq[vt[t].dut][vt[t].idx].q, vt[t].eq, TOL_AX);
            end else begin
                check("tbl_missing", rxq[vt[t].dut].size(), vt[t].idx + 1);
            end
        end

        // Back-to-back frame: gapless output, latency 17, tlast only on the final sample.
        do_reset();
        tx_b = '{8'h00, 8'h01};
        send_stream(1'b1);
        drain();
        compare_model("b2b");
        check("b2b_count", rxq[0].size(), 16 * SPS);
        if (rxcyc.size() > 0) check("b2b_latency", rxcyc[0], acc_cyc + 17);
        ngap = 0;
        nl = 0;
        for (int k = 1; k < rxcyc.size(); k++) if (rxcyc[k] != rxcyc[k-1] + 1) ngap++;
        for (int k = 0; k < rxq[0].size(); k++) if (rxq[0][k].last) nl++;
        check("b2b_gaps", ngap, 0);
        check("b2b_last_count", nl, 1);
        if (rxq[0].size() == 16 * SPS) check("b2b_last_pos", rxq[0][16 * SPS - 1].last, 1);

        // Random backpressure on a random stream
        rnd = 1'b1;
        do_reset();
        tx_b.delete();
        for (int i = 0; i < 6; i++) tx_b.push_back(8'($urandom));
        send_stream(1'b1);
        drain();
        compare_model("bp");
        rnd = 1'b0;

        // Reset mid-byte, then restart from phase 0 / bit 0
        do_reset();
        tx_b = '{8'h3C};
        send_stream(1'b0);
        repeat (30) @(posedge clk);
        do_reset();
        tx_b = '{8'hA5};
        send_stream(1'b1);
        drain();
        compare_model("rst");
        if (rxq[1].size() > 0) begin
            check_tol("rst_first_i", rxq[1][0].i, AX, TOL_AX);
            check_tol("rst_first_q", rxq[1][0].q, 0, TOL_AX);
        end

        // Random frames with an idle gap in between (NCO must hold across it)
        for (int r = 0; r < 3; r++) begin
            do_reset();
            tx_b.delete();
            for (int i = 0; i < $urandom_range(1, 3); i++) tx_b.push_back(8'($urandom));
            send_stream(1'($urandom));
            repeat ($urandom_range(3, 20)) @(posedge clk);
            tx_b.delete();
            for (int i = 0; i < 2; i++) tx_b.push_back(8'($urandom));
            send_stream(1'b1);
            drain();
            compare_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", nfail);
        $fatal(1, "watchdog");
    end

endmodule
